// File: rtl/mnist_bnn_pkg.sv
// Shared types for the MNIST binary neural network datapath.
package mnist_bnn_pkg;

   // Top-level phase sequencer encoding; each layer block watches for its own phase.
   typedef enum logic [2:0] {
      s_IDLE    = 3'd0,
      s_LAYER_1 = 3'd1,
      s_LAYER_2 = 3'd2,
      s_LAYER_3 = 3'd3,
      s_OUTPUT  = 3'd4
   } state_t;

endpackage

// File: rtl/layer_two_if.sv
// Port bundle for the second convolution + 2x2 max-pool layer.
//
// Protocol: there is no per-beat valid/ready. The producer raises state to
// s_LAYER_2 and holds layer_one_out, weights and thresholds stable for as
// long as it stays there; the layer works only while state == s_LAYER_2 and
// raises done once every output bit has been written. done is sticky until
// reset, so the consumer may sample layer_two_out any time after done = 1.
interface layer_two_if #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 16
);
   import mnist_bnn_pkg::*;

   state_t                                 state;
   logic [N_IN-1:0][13:0][13:0]            layer_one_out;
   logic [N_OUT-1:0][N_IN-1:0][2:0][2:0]   weights;
   logic [N_OUT-1:0][6:0]                  thresholds;
   logic [N_OUT-1:0][6:0][6:0]             layer_two_out;
   logic                                   done;

   // Producer / sequencer side.
   modport master (
      output state, layer_one_out, weights, thresholds,
      input  layer_two_out, done
   );

   // Layer side.
   modport slave (
      input  state, layer_one_out, weights, thresholds,
      output layer_two_out, done
   );

endinterface

// File: rtl/layer_two.sv
// Binary 3x3 convolution (XNOR-popcount, zero padded) over N_IN 14x14 maps,
// thresholded per filter and 2x2 max-pooled into N_OUT 7x7 maps.
// One pre-pool pixel is evaluated per active clock edge; a full pass takes
// N_OUT*196 active edges.
module layer_two #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   layer_two_if.slave  bus
);
   import mnist_bnn_pkg::*;

   localparam int FW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(N_OUT - 1);

   logic [FW-1:0]              f_q;
   logic [2:0]                 r_q;
   logic [2:0]                 c_q;
   logic [1:0]                 sub_q;
   logic                       acc_q;
   logic                       done_q;
   logic [N_OUT-1:0][6:0][6:0] out_q;

   logic                       active;
   logic [3:0]                 y_pos;
   logic [3:0]                 x_pos;
   logic [6:0]                 conv;
   logic                       hit;

   // Work only in our phase and only until the pass has finished.
   assign active = (bus.state == s_LAYER_2) && !done_q;

   // Pre-pool coordinate inside the current 2x2 pooling window.
   assign y_pos = {r_q, 1'b0} + {3'd0, sub_q[1]};
   assign x_pos = {c_q, 1'b0} + {3'd0, sub_q[0]};

   // XNOR-popcount of the 3x3xN_IN window; off-map taps read as 0 but still
   // take part in the XNOR, so a weight of 0 matches the padding.
   always_comb begin
      logic [4:0] yy;
      logic [4:0] xx;
      logic       in_bit;
      conv   = '0;
      yy     = '0;
      xx     = '0;
      in_bit = 1'b0;
      for (int ch = 0; ch < N_IN; ch++) begin
         for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
               // One extra bit so y-1 at y=0 becomes 31 and falls out of range.
               yy     = {1'b0, y_pos} + 5'(kr) - 5'd1;
               xx     = {1'b0, x_pos} + 5'(kc) - 5'd1;
               in_bit = 1'b0;
               if ((yy <= 5'd13) && (xx <= 5'd13)) begin
                  in_bit = bus.layer_one_out[ch][yy[3:0]][xx[3:0]];
               end
               conv = conv + {6'd0, ~(in_bit ^ bus.weights[f_q][ch][kr][kc])};
            end
         end
      end
   end

   // Binarise against the current filter's threshold.
   assign hit = (conv >= bus.thresholds[f_q]);

   // Counter walk (sub fastest, then c, r, f), pool accumulator and output write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f_q    <= '0;
         r_q    <= '0;
         c_q    <= '0;
         sub_q  <= '0;
         acc_q  <= 1'b0;
         done_q <= 1'b0;
         out_q  <= '0;
      end else if (active) begin
         sub_q <= sub_q + 2'd1;
         case (sub_q)
            2'd0:    acc_q <= hit;
            2'd1,
            2'd2:    acc_q <= acc_q | hit;
            default: begin
               out_q[f_q][r_q][c_q] <= acc_q | hit;
               if (c_q == 3'd6) begin
                  c_q <= '0;
                  if (r_q == 3'd6) begin
                     r_q <= '0;
                     if (f_q == F_LAST) begin
                        // Last pixel of the last filter: freeze from here on.
                        done_q <= 1'b1;
                     end else begin
                        f_q <= f_q + FW'(1);
                     end
                  end else begin
                     r_q <= r_q + 3'd1;
                  end
               end else begin
                  c_q <= c_q + 3'd1;
               end
            end
         endcase
      end
   end

   assign bus.layer_two_out = out_q;
   assign bus.done          = done_q;

endmodule

// File: tb/tb_layer_two.sv
// Directed bench for layer_two: boundary maps, threshold edges, pause/resume
// and mid-run reset, with a straightforward per-pixel reference model.
module tb_layer_two;
   import mnist_bnn_pkg::*;

   localparam int N_IN  = 8;
   localparam int N_OUT = 16;
   localparam int RUN_EDGES = N_OUT * 196;

   typedef logic [N_OUT-1:0][6:0][6:0]           out_t;
   typedef logic [N_IN-1:0][13:0][13:0]          in_t;
   typedef logic [N_OUT-1:0][N_IN-1:0][2:0][2:0] w_t;
   typedef logic [N_OUT-1:0][6:0]                th_t;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;
   out_t exp_out;
   out_t exp_part;
   int   edges;

   layer_two_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   layer_two #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: per output pixel, max over its 2x2 window of (popcount >= threshold).
   function automatic out_t model(input in_t in_m, input w_t w, input th_t th);
      out_t res;
      res = '0;
      for (int f = 0; f < N_OUT; f++)
         for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) begin
               logic best;
               best = 1'b0;
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     int cnt;
                     cnt = 0;
                     for (int ch = 0; ch < N_IN; ch++)
                        for (int kr = 0; kr < 3; kr++)
                           for (int kc = 0; kc < 3; kc++) begin
                              int  yy;
                              int  xx;
                              logic b;
                              yy = 2 * r + dy + kr - 1;
                              xx = 2 * c + dx + kc - 1;
                              b = 1'b0;
                              if (yy >= 0 && yy <= 13 && xx >= 0 && xx <= 13) b = in_m[ch][yy][xx];
                              if (b == w[f][ch][kr][kc]) cnt++;
                           end
                     if (cnt >= int'(th[f])) best = 1'b1;
                  end
               res[f][r][c] = best;
            end
      return res;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.state = s_IDLE;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_edges(input int n);
      bus.state = s_LAYER_2;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Counts active edges until done is seen; stops at a bound if it never rises.
   task automatic run_to_done(output int n);
      bus.state = s_LAYER_2;
      n = 0;
      while (n < RUN_EDGES + 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.done === 1'b1) break;
      end
   endtask

   task automatic set_pattern();
      for (int ch = 0; ch < N_IN; ch++)
         for (int y = 0; y < 14; y++)
            for (int x = 0; x < 14; x++)
               bus.layer_one_out[ch][y][x] = (((y * 3 + x * 5 + ch * 2) % 7) < 3);
      for (int f = 0; f < N_OUT; f++)
         for (int ch = 0; ch < N_IN; ch++)
            for (int kr = 0; kr < 3; kr++)
               for (int kc = 0; kc < 3; kc++)
                  bus.weights[f][ch][kr][kc] = (((f * 5 + ch * 3 + kr * 2 + kc) % 4) != 0);
      bus.thresholds[0] = 7'd32;
      bus.thresholds[1] = 7'd33;
      bus.thresholds[2] = 7'd48;
      bus.thresholds[3] = 7'd49;
      for (int f = 4; f < N_OUT; f++) bus.thresholds[f] = 7'(20 + 3 * f);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      tests_run++;
      if (bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b expected 0", bus.done);
      end
      tests_run++;
      if (bus.layer_two_out !== '0) begin
         tests_failed++;
         $display("FAIL reset_out: got %0d set bits expected 0", $countones(bus.layer_two_out));
      end
   endtask

   task automatic test_zero_maps();
      bus.layer_one_out = '0;
      bus.weights       = '1;
      bus.thresholds    = {N_OUT{7'd1}};
      do_reset();
      run_to_done(edges);
      tests_run++;
      if (edges != RUN_EDGES) begin
         tests_failed++;
         $display("FAIL zero_th1_edges: got %0d expected %0d", edges, RUN_EDGES);
      end
      tests_run++;
      if (bus.layer_two_out !== '0) begin
         tests_failed++;
         $display("FAIL zero_th1_out: got %0d set bits expected 0", $countones(bus.layer_two_out));
      end
      bus.thresholds = '0;
      do_reset();
      run_to_done(edges);
      tests_run++;
      if (edges != RUN_EDGES || bus.done !== 1'b1) begin
         tests_failed++;
         $display("FAIL zero_th0_edges: got %0d done=%b expected %0d done=1", edges, bus.done, RUN_EDGES);
      end
      tests_run++;
      if (bus.layer_two_out !== '1) begin
         tests_failed++;
         $display("FAIL zero_th0_out: got %0d set bits expected %0d", $countones(bus.layer_two_out), N_OUT * 49);
      end
   endtask

   task automatic test_corners();
      bus.weights    = '1;
      bus.thresholds = {N_OUT{7'd1}};
      bus.layer_one_out = '0;
      bus.layer_one_out[0][0][0] = 1'b1;
      do_reset();
      run_to_done(edges);
      exp_out = '0;
      for (int f = 0; f < N_OUT; f++) exp_out[f][0][0] = 1'b1;
      tests_run++;
      if (bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL corner_top_left: %0d bits differ, got %0d set expected %0d set",
                  $countones(bus.layer_two_out ^ exp_out), $countones(bus.layer_two_out), N_OUT);
      end

      bus.layer_one_out = '0;
      bus.layer_one_out[0][13][13] = 1'b1;
      do_reset();
      run_to_done(edges);
      exp_out = '0;
      for (int f = 0; f < N_OUT; f++) exp_out[f][6][6] = 1'b1;
      tests_run++;
      if (bus.layer_two_out[0][0][0] !== 1'b0 || bus.layer_two_out[N_OUT-1][0][0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL corner_no_wrap: got out[0][0][0]=%b out[last][0][0]=%b expected 0 0",
                  bus.layer_two_out[0][0][0], bus.layer_two_out[N_OUT-1][0][0]);
      end
      tests_run++;
      if (bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL corner_bottom_right: %0d bits differ, got %0d set expected %0d set",
                  $countones(bus.layer_two_out ^ exp_out), $countones(bus.layer_two_out), N_OUT);
      end
   endtask

   task automatic test_all_ones();
      bus.layer_one_out = '1;
      bus.weights       = '1;
      bus.thresholds    = {N_OUT{7'd72}};
      do_reset();
      run_to_done(edges);
      tests_run++;
      if (bus.layer_two_out !== '1) begin
         tests_failed++;
         $display("FAIL ones_th72: got %0d set bits expected %0d", $countones(bus.layer_two_out), N_OUT * 49);
      end
      bus.thresholds = {N_OUT{7'd73}};
      do_reset();
      run_to_done(edges);
      tests_run++;
      if (bus.layer_two_out !== '0) begin
         tests_failed++;
         $display("FAIL ones_th73: got %0d set bits expected 0", $countones(bus.layer_two_out));
      end
   endtask

   task automatic test_pattern();
      set_pattern();
      exp_out = model(bus.layer_one_out, bus.weights, bus.thresholds);
      do_reset();
      run_to_done(edges);
      tests_run++;
      if (bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL pattern_out: %0d bits differ, got %0d set expected %0d set",
                  $countones(bus.layer_two_out ^ exp_out), $countones(bus.layer_two_out), $countones(exp_out));
      end
   endtask

   // Relies on the finished pattern run just before it.
   task automatic test_done_hold();
      bus.state = s_IDLE;
      repeat (5) @(negedge clk);
      bus.state = s_LAYER_2;
      repeat (5) @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL done_hold: got done=%b with %0d differing bits expected done=1 and 0",
                  bus.done, $countones(bus.layer_two_out ^ exp_out));
      end
   endtask

   task automatic test_pause();
      set_pattern();
      exp_out = model(bus.layer_one_out, bus.weights, bus.thresholds);
      // After 1000 active edges exactly the first 250 pixels in f,r,c order are written.
      exp_part = '0;
      for (int f = 0; f < N_OUT; f++)
         for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
               if (f * 49 + r * 7 + c < 250) exp_part[f][r][c] = exp_out[f][r][c];
      do_reset();
      run_edges(1000);
      bus.state = s_IDLE;
      repeat (10) @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.layer_two_out !== exp_part) begin
         tests_failed++;
         $display("FAIL pause_hold: got done=%b with %0d differing bits expected done=0 and 0",
                  bus.done, $countones(bus.layer_two_out ^ exp_part));
      end
      run_to_done(edges);
      tests_run++;
      if (edges != RUN_EDGES - 1000) begin
         tests_failed++;
         $display("FAIL pause_resume_edges: got %0d expected %0d", edges, RUN_EDGES - 1000);
      end
      tests_run++;
      if (bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL pause_result: %0d bits differ", $countones(bus.layer_two_out ^ exp_out));
      end
   endtask

   task automatic test_reset_mid_run();
      set_pattern();
      exp_out = model(bus.layer_one_out, bus.weights, bus.thresholds);
      do_reset();
      run_edges(2000);
      // One reset edge while the layer is still being told to run.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tests_run++;
      if (bus.done !== 1'b0 || bus.layer_two_out !== '0) begin
         tests_failed++;
         $display("FAIL midreset_clear: got done=%b with %0d set bits expected done=0 and 0",
                  bus.done, $countones(bus.layer_two_out));
      end
      run_to_done(edges);
      tests_run++;
      if (edges != RUN_EDGES) begin
         tests_failed++;
         $display("FAIL midreset_edges: got %0d expected %0d", edges, RUN_EDGES);
      end
      tests_run++;
      if (bus.layer_two_out !== exp_out) begin
         tests_failed++;
         $display("FAIL midreset_result: %0d bits differ", $countones(bus.layer_two_out ^ exp_out));
      end
   endtask

   // Sequence of scenarios and final report.
   initial begin
      tests_run         = 0;
      tests_failed      = 0;
      rst_n             = 1'b1;
      bus.state         = s_IDLE;
      bus.layer_one_out = '0;
      bus.weights       = '0;
      bus.thresholds    = '0;

      test_reset();
      test_zero_maps();
      test_corners();
      test_all_ones();
      test_pattern();
      test_done_hold();
      test_pause();
      test_reset_mid_run();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/layer_two.md
LAYER_TWO -- requirements
Module: layer_two

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning number of input feature maps (1..14).
REQ-002 SHALL have parameter N_OUT, default 16, meaning number of output filters (1..16).
REQ-003 SHALL have port clk, input, 1, meaning clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: synchronous, active-low.
REQ-005 SHALL have port state, input, state_t (mnist_bnn_pkg), meaning top-level phase; block is active only when state == s_LAYER_2.
REQ-006 SHALL have port layer_one_out, input, [N_IN-1:0][13:0][13:0], meaning binary input maps indexed [ch][y][x]; held stable by the producer during s_LAYER_2.
REQ-007 SHALL have port weights, input, [N_OUT-1:0][N_IN-1:0][2:0][2:0], meaning binary kernels indexed [f][ch][kr][kc].
REQ-008 SHALL have port thresholds, input, [N_OUT-1:0][6:0], meaning unsigned per-filter popcount threshold.
REQ-009 SHALL have port layer_two_out, output, [N_OUT-1:0][6:0][6:0], registered, meaning pooled binary maps indexed [f][r][c].
REQ-010 SHALL have port done, output, 1, registered, meaning all outputs written.

Function
REQ-011 SHALL hold internal counters f (0..N_OUT-1), r (0..6), c (0..6), sub (0..3), plus a 1-bit pool accumulator acc.
REQ-012 SHALL advance counters only on edges where state == s_LAYER_2 and done == 0 ("active edge"); otherwise all counters, acc, outputs hold.
REQ-013 SHALL order iteration sub fastest, then c, then r, then f; sub 3->0 increments c; c 6->0 increments r; r 6->0 increments f.
REQ-014 SHALL, per active edge, evaluate one pre-pool position y = 2r + sub[1], x = 2c + sub[0].
REQ-015 SHALL compute conv(y,x) = popcount over ch, kr, kc of XNOR(in[ch][y+kr-1][x+kc-1], weights[f][ch][kr][kc]), range 0..9*N_IN, 7-bit unsigned.
REQ-016 SHALL treat any input coordinate outside 0..13 as bit 0 (zero padding, XNOR still applied); no wrap-around.
REQ-017 SHALL compute hit = (conv(y,x) >= thresholds[f]) as unsigned 7-bit compare.
REQ-018 SHALL set acc <= hit when sub == 0, acc <= acc | hit when sub == 1 or 2.
REQ-019 SHALL, on the active edge with sub == 3, write layer_two_out[f][r][c] <= acc | hit (2x2 max pool); no other output bit changes on that edge.
REQ-020 SHALL, on the active edge with f == N_OUT-1, r == 6, c == 6, sub == 3, write the final bit and set done <= 1 on the same edge.
REQ-021 SHALL complete in exactly N_OUT*196 active edges (3136 at defaults); done rises at that edge.
REQ-022 SHALL keep done high and counters frozen until reset, regardless of state.
REQ-023 SHALL NOT reset counters when state leaves s_LAYER_2 mid-run; resume from the held position on re-entry.

Reset
REQ-024 SHALL, on a rising edge with rst_n == 0, clear f, r, c, sub, acc, done and all layer_two_out bits to 0, overriding any other activity.
REQ-025 SHALL, after reset deasserts mid-run, restart from f = 0, r = 0, c = 0, sub = 0 with all outputs 0.

Verification
REQ-026 Zero maps, all weights 1, thresholds 1, state s_LAYER_2 -> after 3136 edges done = 1, all outputs 0; thresholds 0 -> all outputs 1.
REQ-027 Only in[0][0][0] = 1, weights all 1, thresholds 1 -> only out[f][0][0] = 1 for every f; all other bits 0.
REQ-028 Only in[0][13][13] = 1, same weights/thresholds -> only out[f][6][6] = 1; out[f][0][0] = 0 (no wrap).
REQ-029 All maps 1, weights all 1, thresholds 72 -> all outputs 1; thresholds 73 -> all outputs 0; corner conv(0,0) = 32 and edge conv(0,5) = 48 checked with thresholds 32/33 and 48/49 on a reference model.
REQ-030 Drop state out of s_LAYER_2 for 10 cycles at active edge 1000 -> outputs/counters hold; done rises after 3136 active edges total (edge 3146 overall).
REQ-031 Assert rst_n = 0 for one edge at active edge 2000, then run -> all outputs 0 immediately, done = 0, done rises 3136 active edges later with results identical to an uninterrupted run.
